instr_fetch_unit: RTL

- IF stage of the single-issue RISC-V core; generates sequential PCs and fetches from instruction memory over a valid/ready request channel.
- Buffers returned words in a 2-entry in-order queue and presents {pc, instr, opcode} to decode.
- if_opcode drives the opcode input of the main control decoder directly.
- Handles branch redirects from EX by flushing queued and in-flight fetches.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Constants shared across the core: datapath width, the canonical NOP, the base opcodes used by the
// control decoder, and the fetch-unit state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // FLUSH means stale responses are still owed by memory and must be discarded.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// In-order sync FIFO: a push shows at dout the cycle after, with no bypass path.
// It applies no backpressure of its own, so the producer must hold credits; flush overrides push and pop.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && !flush && count == '0));

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: sequential PCs -> imem request channel -> 2-entry queue -> decode; at least 1 cycle from response to if_valid.
// Requests are credit-limited to QDEPTH (in-flight + queued); responses have no backpressure; a redirect flushes everything.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [6:0]      if_opcode
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int EW = 2 * XLEN;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] pcq_head;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   iq_count;
  logic [CW-1:0]   pcq_count;
  logic [CW:0]     credits_used;
  logic [EW-1:0]   iq_head;
  logic            req_fire;
  logic            resp_take;
  logic            pop;
  logic            iq_empty;
  logic            unused_redirect_lsbs;
  fetch_state_e    state;

  // Stale in-flight fetches still hold credits until their responses drain.
  assign credits_used   = {1'b0, inflight} + {1'b0, iq_count};
  assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW + 1)'(QDEPTH));
  assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_take      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

  assign iq_empty  = (iq_count == '0);
  assign if_valid  = !iq_empty && !redirect_valid;
  assign pop       = if_valid && if_ready;
  assign if_instr  = iq_empty ? XLEN'(NOP_INSTR) : iq_head[XLEN-1:0];
  assign if_opcode = if_instr[6:0];
  assign if_pc     = iq_empty ? last_pc : iq_head[EW-1:XLEN];

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    drop_next = drop_cnt;
    if (redirect_valid)
      drop_next = inflight - CW'(imem_resp_valid);
    else if (imem_resp_valid && drop_cnt != '0)
      drop_next = drop_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      last_pc  <= '0;
      state    <= ST_RUN;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
      drop_cnt <= drop_next;
      state    <= (drop_next != '0) ? ST_FLUSH : ST_RUN;
      if (redirect_valid)
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire)
        pc <= pc + XLEN'(4);
      if (pop) last_pc <= iq_head[EW-1:XLEN];
    end
  end

  // Request PCs, matched in order against non-dropped responses.
  fetch_queue #(.W(XLEN), .DEPTH(QDEPTH)) u_pcq (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (req_fire),
    .din   (imem_req_addr),
    .pop   (resp_take),
    .dout  (pcq_head),
    .count (pcq_count)
  );

  fetch_queue #(.W(EW), .DEPTH(QDEPTH)) u_iq (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (resp_take),
    .din   ({pcq_head, imem_resp_data}),
    .pop   (pop),
    .dout  (iq_head),
    .count (iq_count)
  );

  a_state_tracks_drop: assert property (@(posedge clk) disable iff (reset)
    (state == ST_FLUSH) == (drop_cnt != '0));
  a_pcq_matches_live: assert property (@(posedge clk) disable iff (reset)
    pcq_count == inflight - drop_cnt);
  a_resp_was_requested: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> inflight != '0);

endmodule
